// File: rtl/bus_pkg.sv
// bus_pkg: shared ADS bus widths, master FSM states and counter width
package bus_pkg;
    localparam int BUS_ADDR_W = 12;
    localparam int BUS_DATA_W = 8;
    localparam int BM_CNT_W = $clog2(BUS_ADDR_W + 1);
    typedef enum logic [2:0] {IDLE, ADDR, WACK, RWAIT, RDATA, DONE} bm_state_t;
endpackage

// File: rtl/bus_shift_reg.sv
// bus_shift_reg: MSB-first shift register with parallel load, parallel read-out and serial in/out
module bus_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    input  logic         si,
    output logic [W-1:0] q,
    output logic         so
);
    logic [W-1:0] data_q, data_d;
    always_comb data_d = load ? din : shift ? {data_q[W-2:0], si} : data_q;
    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else data_q <= data_d;
    end
    assign q = data_q;
    assign so = data_q[W-1];
endmodule

// File: rtl/bus_master_port.sv
// bus_master_port: ADS bus master; serialises host requests, collects write acks and read data
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_wren,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              validOut,
    output logic              wren,
    output logic              Address,
    output logic              DataOut,
    input  logic              ready,
    input  logic              validIn,
    input  logic              DataIn
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    bm_state_t state_q, state_d;
    logic [BM_CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic wren_q, wren_d, valid_out_q, valid_out_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, rx_par;
    logic tx_load, tx_shift, rx_shift, timeout, last_bit, rx_so_unused;
    logic [2*ADDR_W-1:0] tx_din, tx_par;
    logic [ADDR_W-1:0] tx_hi_unused;
    logic [ADDR_W-2:0] tx_lo_unused;
    // Upper half carries the address, lower half the zero-extended write data,
    // so both lanes shift in lockstep and data lines up with the last address bits.
    bus_shift_reg #(.W(2 * ADDR_W)) u_tx (
        .clk(clk), .rst(rst), .load(tx_load), .shift(tx_shift), .din(tx_din),
        .si(1'b0), .q(tx_par), .so(Address)
    );
    bus_shift_reg #(.W(DATA_W)) u_rx (
        .clk(clk), .rst(rst), .load(1'b0), .shift(rx_shift), .din('0),
        .si(DataIn), .q(rx_par), .so(rx_so_unused)
    );
    assign {tx_hi_unused, DataOut, tx_lo_unused} = tx_par;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        wd_d = (state_q inside {WACK, RWAIT, RDATA}) ? wd_q + 1'b1 : wd_q;
        wren_d = wren_q;
        valid_out_d = valid_out_q;
        busy_d = busy_q;
        done_d = 1'b0;
        err_d = 1'b0;
        rdata_d = rdata_q;
        tx_load = 1'b0;
        tx_shift = 1'b0;
        tx_din = '0;
        rx_shift = 1'b0;
        timeout = wd_q == WD_W'(TIMEOUT - 1);
        last_bit = validIn && cnt_q == BM_CNT_W'(DATA_W - 1);
        case (state_q)
            IDLE: if (req) begin
                state_d = ADDR;
                cnt_d = '0;
                wren_d = req_wren;
                valid_out_d = 1'b1;
                busy_d = 1'b1;
                tx_load = 1'b1;
                tx_din = {req_addr, ADDR_W'({DATA_W{req_wren}} & req_wdata)};
            end
            ADDR: begin
                cnt_d = cnt_q + 1'b1;
                tx_shift = 1'b1;
                if (cnt_q == BM_CNT_W'(ADDR_W - 1)) begin
                    state_d = wren_q ? WACK : RWAIT;
                    cnt_d = '0;
                    wd_d = '0;
                    valid_out_d = 1'b0;
                    tx_load = 1'b1;
                end
            end
            WACK: if (ready || timeout) begin
                state_d = DONE;
                done_d = 1'b1;
                busy_d = 1'b0;
                err_d = !ready;
            end
            RWAIT: if (timeout) begin
                state_d = DONE;
                done_d = 1'b1;
                busy_d = 1'b0;
                err_d = 1'b1;
            end else if (validIn) begin
                state_d = RDATA;
                rx_shift = 1'b1;
                cnt_d = BM_CNT_W'(1);
            end
            RDATA: if (cnt_q == BM_CNT_W'(DATA_W)) begin
                state_d = DONE;
                done_d = 1'b1;
                busy_d = 1'b0;
                rdata_d = rx_par;
            end else if (timeout && !last_bit) begin
                state_d = DONE;
                done_d = 1'b1;
                busy_d = 1'b0;
                err_d = 1'b1;
            end else if (validIn) begin
                rx_shift = 1'b1;
                cnt_d = cnt_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                wren_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            wd_q <= '0;
            wren_q <= 1'b0;
            valid_out_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            wd_q <= wd_d;
            wren_q <= wren_d;
            valid_out_q <= valid_out_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
            rdata_q <= rdata_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
    assign rdata = rdata_q;
    assign validOut = valid_out_q;
    assign wren = wren_q;
endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: table-driven and randomised checks of bus_master_port against a transaction-level model
module tb_bus_master_port;
    localparam int A = 12;
    localparam int D = 8;
    localparam int T = 255;
    logic clk = 1'b0, rst = 1'b1, req = 1'b0, req_wren = 1'b0;
    logic ready = 1'b0, validIn = 1'b0, DataIn = 1'b0;
    logic [A-1:0] req_addr = '0;
    logic [D-1:0] req_wdata = '0;
    logic busy, done, err, validOut, wren, Address, DataOut;
    logic [D-1:0] rdata;
    int n_tests = 0, n_fail = 0;
    logic [D-1:0] model_rd = '0;

    typedef struct {
        bit w;
        logic [A-1:0] a;
        logic [D-1:0] d;
        int delay;
        int gap_at;
        int gap_len;
        bit respond;
    } txn_t;
    typedef struct {
        txn_t t;
        logic [A-1:0] ea;
        logic [A-1:0] ed;
        int em;
        bit eerr;
        logic [D-1:0] erd;
    } vec_t;
    vec_t tbl[9];

    bus_master_port #(.ADDR_W(A), .DATA_W(D), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wren(req_wren), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .validOut(validOut), .wren(wren), .Address(Address), .DataOut(DataOut),
        .ready(ready), .validIn(validIn), .DataIn(DataIn)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait-phase edges are numbered from 1 (first edge after the frame ends).
    // Write succeeds if ready is seen by edge T; read succeeds if its last bit arrives by edge T,
    // finishing one edge after that bit.
    function automatic void model(input txn_t t, output logic [A-1:0] ea, output logic [A-1:0] ed,
                                  output int em, output bit eerr, inout logic [D-1:0] rd);
        int e;
        bit ok;
        e = t.w ? t.delay + 1 : t.delay + D + (t.gap_at < D ? t.gap_len : 0);
        ok = t.respond && e <= T;
        ea = t.a;
        ed = t.w ? A'(t.d) : '0;
        em = !ok ? T : t.w ? e : e + 1;
        eerr = !ok;
        if (ok && !t.w) rd = t.d;
    endfunction

    task automatic run_txn(input txn_t t, input logic [A-1:0] ea, input logic [A-1:0] ed,
                           input int em, input bit eerr, input logic [D-1:0] erd, input bit noise);
        logic [A-1:0] fa, fd, fv;
        int m, i;
        @(negedge clk);
        req = 1'b1; req_wren = t.w; req_addr = t.a; req_wdata = t.d;
        for (int k = 0; k <= A; k++) begin
            @(negedge clk);
            req = noise ? 1'($urandom) : 1'b0;
            if (k == 0) chk("frame_busy_wren", {busy, wren}, {1'b1, t.w});
            if (k < A) begin
                fa[A-1-k] = Address;
                fd[A-1-k] = DataOut;
                fv[A-1-k] = validOut;
            end else chk("frame_tail", {validOut, Address, DataOut}, 3'b0);
        end
        chk("frame_valid", fv, {A{1'b1}});
        chk("frame_addr", fa, ea);
        chk("frame_data", fd, ed);
        for (m = 1; m <= T + 2; m++) begin
            i = m - t.delay - 1;
            if (i >= t.gap_at) i = (i < t.gap_at + t.gap_len) ? -1 : i - t.gap_len;
            if (t.w) begin
                ready = t.respond && m > t.delay;
                validIn = noise ? 1'($urandom) : 1'b0;
                DataIn = 1'($urandom);
            end else begin
                ready = noise ? 1'($urandom) : 1'b0;
                validIn = t.respond && i >= 0 && i < D;
                DataIn = validIn ? t.d[D-1-i] : 1'($urandom);
            end
            req = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
            if (done) break;
        end
        chk("done_edge", m, em);
        chk("err", err, eerr);
        chk("rdata", rdata, erd);
        req = 1'b0; ready = 1'b0; validIn = 1'b0; DataIn = 1'b0;
        @(negedge clk);
        chk("after_done", {done, busy, validOut, wren}, 4'b0);
    endtask

    initial begin
        txn_t t;
        logic [A-1:0] ea, ed;
        int em, nd;
        bit eerr;
        logic [3*(A+3)-1:0] bv, bd, ev, edn;
        tbl[0] = '{'{1'b1, 12'h4D9, 8'hE5, 3, 0, 0, 1'b1}, 12'h4D9, 12'h0E5, 4, 1'b0, 8'h00};
        tbl[1] = '{'{1'b0, 12'h123, 8'hA6, 5, 0, 0, 1'b1}, 12'h123, 12'h000, 14, 1'b0, 8'hA6};
        tbl[2] = '{'{1'b0, 12'h7FF, 8'h5C, 0, 3, 4, 1'b1}, 12'h7FF, 12'h000, 13, 1'b0, 8'h5C};
        tbl[3] = '{'{1'b1, 12'hABC, 8'h3C, 0, 0, 0, 1'b0}, 12'hABC, 12'h03C, 255, 1'b1, 8'h5C};
        tbl[4] = '{'{1'b1, 12'h001, 8'hFF, 254, 0, 0, 1'b1}, 12'h001, 12'h0FF, 255, 1'b0, 8'h5C};
        tbl[5] = '{'{1'b0, 12'h800, 8'h81, 0, 0, 0, 1'b1}, 12'h800, 12'h000, 9, 1'b0, 8'h81};
        tbl[6] = '{'{1'b1, 12'hFFF, 8'h00, 0, 0, 0, 1'b1}, 12'hFFF, 12'h000, 1, 1'b0, 8'h81};
        tbl[7] = '{'{1'b0, 12'h555, 8'h3E, 247, 0, 0, 1'b1}, 12'h555, 12'h000, 256, 1'b0, 8'h3E};
        tbl[8] = '{'{1'b0, 12'h0AA, 8'h99, 248, 0, 0, 1'b1}, 12'h0AA, 12'h000, 255, 1'b1, 8'h3E};

        repeat (3) @(negedge clk);
        chk("reset_state", {validOut, wren, Address, DataOut, busy, done, err, rdata}, '0);
        rst = 1'b0;

        for (int n = 0; n < 9; n++) begin
            run_txn(tbl[n].t, tbl[n].ea, tbl[n].ed, tbl[n].em, tbl[n].eerr, tbl[n].erd, 1'b0);
            model_rd = tbl[n].erd;
        end

        @(negedge clk);
        req = 1'b1; req_wren = 1'b1; req_addr = 12'h3B5; req_wdata = 8'h77;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            req = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outputs", {validOut, wren, Address, DataOut, busy, done, err, rdata}, '0);
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            nd += int'(done) + int'(validOut);
        end
        chk("rst_no_done", nd, 0);
        model_rd = '0;
        t = '{1'b1, 12'h3B5, 8'h77, 2, 0, 0, 1'b1};
        model(t, ea, ed, em, eerr, model_rd);
        run_txn(t, ea, ed, em, eerr, model_rd, 1'b0);

        @(negedge clk);
        req = 1'b1; req_wren = 1'b1; ready = 1'b1; req_addr = 12'h5A5; req_wdata = 8'h11;
        for (int n = 0; n < 3 * (A + 3); n++) begin
            @(negedge clk);
            bv[n] = validOut;
            bd[n] = done;
            ev[n] = (n % (A + 3)) < A;
            edn[n] = (n % (A + 3)) == A + 1;
        end
        req = 1'b0; ready = 1'b0;
        chk("b2b_valid", bv, ev);
        chk("b2b_done", bd, edn);
        repeat (2) @(negedge clk);

        for (int r = 0; r < 20; r++) begin
            t.w = 1'($urandom);
            t.a = A'($urandom);
            t.d = D'($urandom);
            t.delay = $urandom_range(0, 6);
            t.gap_at = $urandom_range(1, D - 1);
            t.gap_len = $urandom_range(0, 5);
            t.respond = $urandom_range(0, 9) != 0;
            model(t, ea, ed, em, eerr, model_rd);
            run_txn(t, ea, ed, em, eerr, model_rd, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_master_port.md
# bus_master_port

Master-side serial port for the ADS bus. It accepts a parallel read or write request from a host, such as an arbiter or processor model. It serialises the address, and for writes the data, onto the 1-bit bus lines that feed `slave`, then collects the write acknowledge or deserialises the returned read data. A watchdog aborts any transaction the slave never answers.

## Interface
Parameters:
- `ADDR_W`, 12: address bits per frame.
- `DATA_W`, 8: data bits per word; `DATA_W <= ADDR_W`.
- `TIMEOUT`, 255: maximum number of wait cycles for a slave response.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  1: host request; sampled only in IDLE.
- `req_wren`  in  1: 1 = write, 0 = read.
- `req_addr`  in  ADDR_W: target address.
- `req_wdata`  in  DATA_W: write data.
- `busy`  out  1: high from the cycle after `req` is accepted until DONE.
- `done`  out  1: one-cycle pulse marking transaction end.
- `err`  out  1: valid with `done`; 1 = timeout.
- `rdata`  out  DATA_W: read result; held until the next read completes.
- `validOut`  out  1: frame strobe to slave `validIn`.
- `wren`  out  1: to slave `wren`; held for the whole transaction.
- `Address`  out  1: serial address to slave `Address`.
- `DataOut`  out  1: serial write data to slave `DataIn`.
- `ready`  in  1: slave write-complete; sampled on a level.
- `validIn`  in  1: slave read-data strobe, from slave `validOut`.
- `DataIn`  in  1: serial read data, from slave `DataOut`.

## Operation
- States: IDLE, ADDR, WACK, RWAIT, RDATA, DONE.
- IDLE: when `req`=1, latch `req_wren`, `req_addr` and `req_wdata` into shift registers and go to ADDR. Requests in all other states are ignored, not queued.
- ADDR: lasts exactly ADDR_W cycles.
  - `validOut`=1.
  - `Address` carries address bit ADDR_W-1-k in frame cycle k (MSB first).
  - Write: `DataOut` carries data bit DATA_W-1-j in frame cycle ADDR_W-DATA_W+j, so the data is aligned with the last DATA_W address bits. `DataOut` is 0 in all other cycles.
  - Read: `DataOut` is 0 throughout.
  - After the last bit, go to WACK for a write or RWAIT for a read. The watchdog clears on this transition.
- WACK: when `ready`=1, go to DONE with `err`=0.
- RWAIT: when `validIn`=1, shift in `DataIn` and go to RDATA with the bit count at 1.
- RDATA: shift `DataIn` MSB first while `validIn`=1; after DATA_W bits, load `rdata` and go to DONE.
  - If `validIn` drops early, hold the count and keep the watchdog running.
- Watchdog: counts cycles in WACK, RWAIT and RDATA. When it reaches TIMEOUT, go to DONE with `err`=1 and leave `rdata` unchanged.
- DONE: one cycle with `done`=1, then IDLE. `wren` returns to 0 in IDLE.
- If `ready` and the timeout occur in the same cycle, `ready` wins (`err`=0). The same rule applies when the last data bit and the timeout coincide.

## Timing
- Reset values: `validOut`=0, `wren`=0, `Address`=0, `DataOut`=0, `busy`=0, `done`=0, `err`=0, `rdata`=0, state IDLE, all counters 0.
- `rst` in any state aborts the transaction with no `done` pulse. Bus lines are 0 the cycle after.
- All outputs are registered.
- `req` sampled at edge t: `validOut` rises at t+1 and stays high through t+ADDR_W.
- Write latency: if `ready` is first sampled high at edge r, `done` is high during cycle r+1.
- Minimum write latency is ADDR_W+2 cycles from `req`.
- Minimum read latency is ADDR_W+DATA_W+2 cycles from `req`.
- Back-to-back: a new `req` is accepted in the cycle after DONE.

## Structure
- Package `bus_pkg`:
  - ADDR_W/DATA_W defaults shared with `slave`.
  - State enum `bm_state_t`.
  - Localparam for the counter width, `$clog2(ADDR_W+1)`.
- One sub-module: `bus_shift_reg`, a parameterised MSB-first shift register with parallel load, parallel read-out, shift enable and serial in/out. Instantiate it twice, once for address/data transmit and once for read-data receive.
- Watchdog and FSM stay in the top module.
- Target: about 200 lines of RTL.

## Test plan
- Write `req_addr`=0x4D9, `req_wdata`=0xE5 → `Address` sequence 0,1,0,0,1,1,0,1,1,0,0,1 with `validOut` high for 12 cycles. `DataOut` is 1,1,1,0,0,1,0,1 in frame cycles 4–11. Assert `ready` 3 cycles later → `done`=1, `err`=0.
- Read `req_addr`=0x123; a slave model returns 0xA6 after 5 cycles → `rdata`=0xA6, `done` with `err`=0, `DataOut` 0 throughout.
- Read where `validIn` drops for 4 cycles mid-word → `rdata` is still assembled correctly with no lost or duplicated bits.
- Write with no `ready` → `done`=1 and `err`=1 exactly TIMEOUT cycles after the frame ends; prior `rdata` unchanged. Repeat with `ready` on the timeout cycle → `err`=0.
- `rst` pulsed in ADDR cycle 6 → all outputs at reset values the next cycle, no `done` pulse; a following write completes normally.
- `req` held high continuously → transactions run back-to-back with exactly one IDLE cycle between DONE and the next frame.
